// File: rtl/cache_ram_port_pkg.sv
// cache_ram_port_pkg: shared RAM select codes, FSM state encoding and line geometry
package cache_ram_port_pkg;
    localparam int WORD_IDX_W = 3;
    localparam logic [1:0] SEL_IC = 2'b00;
    localparam logic [1:0] SEL_DC = 2'b01;
    localparam logic [1:0] SEL_RSVD = 2'b10;
    localparam logic [1:0] SEL_DC_WB = 2'b11;
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/cache_ram_port_if.sv
// cache_ram_port_if: per-word RAM command inputs and memory req/ack bus of cache_ram_port
interface cache_ram_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORD_IDX_W = cache_ram_port_pkg::WORD_IDX_W
);
    logic ram_en_in;
    logic ram_write_in;
    logic [1:0] ram_addr_sel_in;
    logic [WORD_IDX_W-1:0] counter_in;
    logic [ADDR_W-1:0] ic_addr_in;
    logic [ADDR_W-1:0] dc_addr_in;
    logic [ADDR_W-1:0] dc_wb_addr_in;
    logic [DATA_W-1:0] wb_data_in;
    logic mem_req_out;
    logic mem_we_out;
    logic [ADDR_W-1:0] mem_addr_out;
    logic [DATA_W-1:0] mem_wdata_out;
    logic mem_ack_in;
    logic [DATA_W-1:0] mem_rdata_in;
    logic [DATA_W-1:0] fill_data_out;
    logic [WORD_IDX_W-1:0] fill_idx_out;
    logic word_done_out;
    logic busy_out;
    logic err_out;
    modport master (
        output ram_en_in, ram_write_in, ram_addr_sel_in, counter_in, ic_addr_in, dc_addr_in,
               dc_wb_addr_in, wb_data_in, mem_ack_in, mem_rdata_in,
        input  mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, fill_data_out, fill_idx_out,
               word_done_out, busy_out, err_out
    );
    modport slave (
        input  ram_en_in, ram_write_in, ram_addr_sel_in, counter_in, ic_addr_in, dc_addr_in,
               dc_wb_addr_in, wb_data_in, mem_ack_in, mem_rdata_in,
        output mem_req_out, mem_we_out, mem_addr_out, mem_wdata_out, fill_data_out, fill_idx_out,
               word_done_out, busy_out, err_out
    );
endinterface

// File: rtl/cache_ram_port_addr_gen.sv
// cache_ram_port_addr_gen: picks the line base by RAM select and inserts the word offset
module cache_ram_port_addr_gen import cache_ram_port_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int WORD_IDX_W = cache_ram_port_pkg::WORD_IDX_W
) (
    input  logic [1:0] sel,
    input  logic [WORD_IDX_W-1:0] idx,
    input  logic [ADDR_W-1:0] ic_addr,
    input  logic [ADDR_W-1:0] dc_addr,
    input  logic [ADDR_W-1:0] dc_wb_addr,
    output logic [ADDR_W-1:0] addr,
    output logic bad_sel
);
    logic [ADDR_W-1:0] base;
    logic unused_lo;
    // the reserved code falls back to the D-cache miss address
    assign base = sel == SEL_IC ? ic_addr : sel == SEL_DC_WB ? dc_wb_addr : dc_addr;
    assign addr = {base[ADDR_W-1:WORD_IDX_W+2], idx, 2'b00};
    assign bad_sel = sel == SEL_RSVD;
    assign unused_lo = ^base[WORD_IDX_W+1:0];
endmodule

// File: rtl/cache_ram_port.sv
// cache_ram_port: registered req/ack memory engine issuing one cache line word per command
// Optional CACHE_RAM_TIMEOUT_EN: ack watchdog that forces completion and flags err_out.
module cache_ram_port import cache_ram_port_pkg::*; #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int WORD_IDX_W = cache_ram_port_pkg::WORD_IDX_W
`ifdef CACHE_RAM_TIMEOUT_EN
    , parameter int TIMEOUT = 64
`endif
) (
    input logic clk,
    input logic reset,
    cache_ram_port_if.slave bus
);
    state_e state;
    logic [WORD_IDX_W-1:0] idx;
    logic [ADDR_W-1:0] gen_addr;
    logic bad_sel;
`ifdef CACHE_RAM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);
    logic [CNT_W-1:0] cnt;
`endif
    cache_ram_port_addr_gen #(.ADDR_W(ADDR_W), .WORD_IDX_W(WORD_IDX_W)) u_addr_gen (
        .sel(bus.ram_addr_sel_in),
        .idx(bus.counter_in),
        .ic_addr(bus.ic_addr_in),
        .dc_addr(bus.dc_addr_in),
        .dc_wb_addr(bus.dc_wb_addr_in),
        .addr(gen_addr),
        .bad_sel(bad_sel)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx <= '0;
            bus.mem_req_out <= 1'b0;
            bus.mem_we_out <= 1'b0;
            bus.mem_addr_out <= '0;
            bus.mem_wdata_out <= {DATA_W{1'b0}};
            bus.fill_data_out <= '0;
            bus.fill_idx_out <= '0;
            bus.word_done_out <= 1'b0;
            bus.busy_out <= 1'b0;
            bus.err_out <= 1'b0;
`ifdef CACHE_RAM_TIMEOUT_EN
            cnt <= '0;
`endif
        end else begin
            bus.word_done_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.mem_ack_in || (bus.ram_en_in && bad_sel)) bus.err_out <= 1'b1;
                    if (bus.ram_en_in) begin
                        state <= REQ;
                        idx <= bus.counter_in;
                        bus.mem_req_out <= 1'b1;
                        bus.busy_out <= 1'b1;
                        bus.mem_we_out <= bus.ram_write_in;
                        bus.mem_addr_out <= gen_addr;
                        bus.mem_wdata_out <= bus.wb_data_in;
`ifdef CACHE_RAM_TIMEOUT_EN
                        cnt <= '0;
`endif
                    end
                end
                REQ: begin
                    if (bus.mem_ack_in) begin
                        state <= DONE;
                        bus.mem_req_out <= 1'b0;
                        bus.mem_we_out <= 1'b0;
                        bus.word_done_out <= 1'b1;
                        if (!bus.mem_we_out) begin
                            bus.fill_data_out <= bus.mem_rdata_in;
                            bus.fill_idx_out <= idx;
                        end
                    end
`ifdef CACHE_RAM_TIMEOUT_EN
                    else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        state <= DONE;
                        bus.mem_req_out <= 1'b0;
                        bus.mem_we_out <= 1'b0;
                        bus.word_done_out <= 1'b1;
                        bus.err_out <= 1'b1;
                        if (!bus.mem_we_out) begin
                            bus.fill_data_out <= '0;
                            bus.fill_idx_out <= idx;
                        end
                    end
                    cnt <= cnt + 1'b1;
`endif
                end
                DONE: begin
                    if (bus.mem_ack_in) bus.err_out <= 1'b1;
                    state <= IDLE;
                    bus.busy_out <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cache_ram_port.md
Name: cache_ram_port

Overview:
- Memory-side transaction engine directly downstream of the cache controller's combinational control logic.
- Turns per-word RAM commands (enable, write, address select, word counter) into a registered req/ack handshake to the main memory.
- Returns fill data for the I-cache or D-cache line being loaded.
- Raises a one-cycle completion pulse so the cache manage unit advances the status/counter registers only when the memory word has actually finished.

Parameters:
- ADDR_W, 32, byte address width.
- DATA_W, 32, memory/cache word width.
- WORD_IDX_W, 3, word-in-line index width (8 words/line).
- TIMEOUT, 64, ack watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- ram_en_in  in  1  word access requested this cycle.
- ram_write_in  in  1  1 = write-back word to memory, 0 = read fill word.
- ram_addr_sel_in  in  2  00 I-cache fill, 01 D-cache fill, 11 D-cache write-back, 10 reserved.
- counter_in  in  WORD_IDX_W  word index within line.
- ic_addr_in  in  ADDR_W  missing I-cache address.
- dc_addr_in  in  ADDR_W  missing D-cache address.
- dc_wb_addr_in  in  ADDR_W  victim line address (tag+index).
- wb_data_in  in  DATA_W  D-cache word being written back.
- mem_req_out  out  1  memory request valid.
- mem_we_out  out  1  memory write strobe.
- mem_addr_out  out  ADDR_W  word-aligned memory address.
- mem_wdata_out  out  DATA_W  write data.
- mem_ack_in  in  1  memory completion.
- mem_rdata_in  in  DATA_W  read data, valid with mem_ack_in.
- fill_data_out  out  DATA_W  captured read word.
- fill_idx_out  out  WORD_IDX_W  word index of fill_data_out.
- word_done_out  out  1  one-cycle completion pulse.
- busy_out  out  1  transaction in flight.
- err_out  out  1  sticky protocol error.

Behaviour:
- FSM states: IDLE, REQ, DONE.
- Reset: state=IDLE; all outputs 0; err_out=0.
- IDLE:
  - ram_en_in=1: latch we, idx=counter_in, address and write data; go to REQ.
  - ram_en_in=0: stay in IDLE, no memory access, no word_done_out. The manage unit advances the counter itself when ram_en_in=0 (coherence hit path).
- Address formation:
  - base = ic_addr_in for select 00, dc_addr_in for 01, dc_wb_addr_in for 11.
  - mem_addr_out = {base[ADDR_W-1:WORD_IDX_W+2], idx, 2'b00}.
  - Select 10 uses dc_addr_in and sets err_out.
- REQ:
  - mem_req_out=1 and busy_out=1.
  - mem_we_out, mem_addr_out and mem_wdata_out are held stable from the latched values.
  - Input changes during REQ are ignored.
  - On mem_ack_in=1: if a read, capture mem_rdata_in into fill_data_out and set fill_idx_out=idx; go to DONE.
- DONE:
  - word_done_out=1, busy_out=1, mem_req_out=0.
  - Next cycle return to IDLE; a new ram_en_in is sampled only in IDLE.
- Latency:
  - Ack in the first REQ cycle gives word_done_out 2 cycles after ram_en_in is sampled.
  - Otherwise latency is 2 + ack wait cycles.
  - Line of 8 words: at least 3 cycles/word.
- fill_data_out / fill_idx_out hold their values until the next read ack; they are not modified by writes.
- mem_ack_in in IDLE or DONE: ignored and sets err_out (stale ack, including after reset).
- Reset mid-REQ: mem_req_out drops at the next edge; no word_done_out is issued.
- err_out is cleared only by reset.

Optional Feature:
- Macro CACHE_RAM_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in REQ.
  - If no ack arrives after TIMEOUT cycles: set err_out, force DONE with fill_data_out=0 to avoid deadlock.
- Undefined:
  - No counter; REQ waits indefinitely.

Decomposition:
- Shared package/header status.vh additions:
  - RAM select codes SEL_IC=2'b00, SEL_DC=2'b01, SEL_DC_WB=2'b11.
  - FSM state encodings.
  - WORD_IDX_W.
- Natural sub-module cache_ram_addr_gen: combinational select + word-offset address builder, reusable by the manage unit.

Test Plan:
- IC fill read: sel=00, ic_addr=0x0000_1234, counter=5, immediate ack, rdata=0xDEADBEEF -> mem_addr=0x0000_1234 with bits[4:0]=10100 (0x0000_1234), word_done 2 cycles later, fill_data=0xDEADBEEF, fill_idx=5.
- DC write-back: sel=11, dc_wb_addr=0x0000_8000, counter=7, wb_data=0x12345678, ack after 4 cycles -> mem_we=1, addr=0x0000_801C, wdata stable throughout REQ, word_done 6 cycles after sampling, fill_data unchanged.
- Full 8-word DC fill with random ack delays 0-5 -> 8 word_done pulses, fill_idx 0..7 in order, no overlapping requests.
- Inputs toggled during REQ (sel and counter changed) -> mem_addr/mem_we unchanged until DONE.
- Reset asserted in REQ, ack arrives the cycle after -> mem_req=0, no word_done, err_out=1.
- With CACHE_RAM_TIMEOUT_EN, no ack for 64 cycles -> err_out=1, word_done pulse, fill_data=0; without the macro, busy_out stays 1.
